// File: rtl/elevator_pkg.sv
// Shared elevator constants and the SCAN state encoding used by the
// floor request queue.
package elevator_pkg;

  localparam int NUM_FLOORS      = 7;
  localparam int FLOOR_W         = 3;
  localparam int DEBOUNCE_CYCLES = 1000000;
  localparam int CNT_W           = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } scan_state_e;

endpackage

// File: rtl/btn_debounce.sv
// One call button: 2-flop synchroniser, stability counter and a single-cycle
// pulse on each accepted press (releases are accepted silently).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = elevator_pkg::DEBOUNCE_CYCLES,
  parameter int CNT_W           = elevator_pkg::CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync0;
  logic             sync1;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             flip;

  assign differ = sync1 ^ stable;
  assign flip   = differ && (cnt == CNT_LAST);
  // Press coincides with the cycle the stable value is about to flip high.
  assign press  = flip && sync1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0  <= 1'b0;
      sync1  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync0 <= raw;
      sync1 <= sync0;
      if (!differ) begin
        cnt <= '0;
      end else if (flip) begin
        stable <= sync1;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/floor_request_queue.sv
// Debounces floor call buttons, latches pending requests and picks the next
// target floor with a SCAN (sweep-then-reverse) policy.
module floor_request_queue #(
  parameter int NUM_FLOORS      = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W         = elevator_pkg::FLOOR_W,
  parameter int DEBOUNCE_CYCLES = elevator_pkg::DEBOUNCE_CYCLES,
  parameter int CNT_W           = elevator_pkg::CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] btn,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  arrived,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic                  target_valid,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up
);

  import elevator_pkg::*;

  // Handshake: target_floor is meaningful while target_valid is high; the
  // controller answers with a one-cycle arrived pulse at cur_floor, which
  // retires that floor's request. There is no backpressure on either side.

  scan_state_e           state;
  scan_state_e           state_next;
  logic [NUM_FLOORS-1:0] press;
  logic [NUM_FLOORS-1:0] clear;
  logic                  cur_ok;
  logic [FLOOR_W-1:0]    cur_eff;
  logic                  above;
  logic                  below;
  logic [FLOOR_W-1:0]    up_pick;
  logic [FLOOR_W-1:0]    down_pick;
  logic [FLOOR_W-1:0]    target_next;
  logic                  dir_next;

  for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (btn[g]),
      .press(press[g])
    );
  end

  // An out-of-range floor report never retires anything and reads as floor 1.
  assign cur_ok  = (cur_floor != '0) && (cur_floor <= FLOOR_W'(NUM_FLOORS));
  assign cur_eff = cur_ok ? cur_floor : FLOOR_W'(1);

  always_comb begin
    clear = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      clear[i] = arrived && cur_ok && (cur_floor == FLOOR_W'(i + 1));
    end
  end

  // Clear wins over a same-cycle press: that floor is being served now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending | press) & ~clear;
    end
  end

  always_comb begin
    above     = 1'b0;
    below     = 1'b0;
    up_pick   = '0;
    down_pick = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (FLOOR_W'(i + 1) >= cur_eff)) begin
        above   = 1'b1;
        up_pick = FLOOR_W'(i + 1);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (FLOOR_W'(i + 1) <= cur_eff)) begin
        below     = 1'b1;
        down_pick = FLOOR_W'(i + 1);
      end
    end
  end

  always_comb begin
    state_next  = state;
    target_next = '0;
    dir_next    = dir_up;
    case (state)
      IDLE: begin
        if (pending != '0) state_next = above ? UP : DOWN;
      end
      UP: begin
        if (pending == '0) state_next = IDLE;
        else if (!above)   state_next = DOWN;
      end
      DOWN: begin
        if (pending == '0) state_next = IDLE;
        else if (!below)   state_next = UP;
      end
      default: state_next = IDLE;
    endcase
    case (state_next)
      UP: begin
        target_next = up_pick;
        dir_next    = 1'b1;
      end
      DOWN: begin
        target_next = down_pick;
        dir_next    = 1'b0;
      end
      default: begin
        target_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      target_floor <= '0;
      target_valid <= 1'b0;
      dir_up       <= 1'b1;
    end else begin
      state        <= state_next;
      target_floor <= target_next;
      target_valid <= |pending;
      dir_up       <= dir_next;
    end
  end

endmodule

// File: tb/tb_floor_request_queue.sv
// Directed bench for floor_request_queue with a 4-cycle debounce.
module tb_floor_request_queue;

  logic       clk;
  logic       rst_n;
  logic [6:0] btn;
  logic [2:0] cur_floor;
  logic       arrived;
  logic [2:0] target_floor;
  logic       target_valid;
  logic [6:0] pending;
  logic       dir_up;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  floor_request_queue #(
    .NUM_FLOORS     (7),
    .FLOOR_W        (3),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn         (btn),
    .cur_floor   (cur_floor),
    .arrived     (arrived),
    .target_floor(target_floor),
    .target_valid(target_valid),
    .pending     (pending),
    .dir_up      (dir_up)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    btn     = '0;
    arrived = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic press_floors(input logic [6:0] mask);
    btn = mask;
    repeat (8) tick();
    btn = '0;
    repeat (8) tick();
  endtask

  task automatic arrive(input logic [2:0] f);
    cur_floor = f;
    arrived   = 1'b1;
    tick();
    arrived = 1'b0;
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    btn       = '0;
    cur_floor = 3'd1;
    arrived   = 1'b0;

    // 1. reset then idle
    do_reset();
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_target", 32'(target_floor), 32'h0);
    check("rst_valid", 32'(target_valid), 32'h0);
    check("rst_dir", 32'(dir_up), 32'h1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_outputs", 32'({pending, target_valid, target_floor, dir_up}), 32'h001);
    end

    // 2. bounce rejection then exact press latency
    cur_floor = 3'd1;
    for (int i = 0; i < 20; i++) begin
      btn[4] = ((i % 4) < 2);
      tick();
      check("bounce_pending", 32'(pending), 32'h0);
    end
    btn[4] = 1'b1;
    repeat (5) tick();
    check("press_early", 32'(pending), 32'h0);
    tick();
    check("press_at_6", 32'(pending), 32'h10);
    check("target_lag", 32'(target_floor), 32'h0);
    tick();
    check("target_f5", 32'(target_floor), 32'h5);
    check("valid_f5", 32'(target_valid), 32'h1);
    check("dir_f5", 32'(dir_up), 32'h1);
    btn = '0;
    repeat (8) tick();
    check("release_ignored", 32'(pending), 32'h10);

    // 3. SCAN up then down
    do_reset();
    cur_floor = 3'd3;
    exp_q.push_back(32'd5);
    exp_q.push_back(32'd7);
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd0);
    press_floors(7'b1010010);
    check("scan_pending", 32'(pending), 32'h52);
    check("scan_dir_up", 32'(dir_up), 32'h1);
    check("scan_t1", 32'(target_floor), exp_q.pop_front());
    arrive(3'd5);
    check("scan_clear5", 32'(pending), 32'h42);
    check("scan_t2", 32'(target_floor), exp_q.pop_front());
    arrive(3'd7);
    check("scan_t3", 32'(target_floor), exp_q.pop_front());
    check("scan_dir_down", 32'(dir_up), 32'h0);
    arrive(3'd2);
    check("scan_t4", 32'(target_floor), exp_q.pop_front());
    check("scan_valid0", 32'(target_valid), 32'h0);
    check("scan_pending0", 32'(pending), 32'h0);
    check("idle_dir_hold", 32'(dir_up), 32'h0);

    // 4. preemption by a closer request ahead
    do_reset();
    cur_floor = 3'd2;
    press_floors(7'b0100000);
    check("pre_t6", 32'(target_floor), 32'h6);
    check("pre_dir", 32'(dir_up), 32'h1);
    btn[3] = 1'b1;
    begin
      int waited;
      waited = 0;
      while (!pending[3] && waited < 20) begin
        tick();
        waited++;
      end
      check("pre_wait_ok", 32'(pending[3]), 32'h1);
    end
    check("pre_t_old", 32'(target_floor), 32'h6);
    tick();
    check("pre_t4", 32'(target_floor), 32'h4);
    check("pre_f6_kept", 32'(pending), 32'h28);
    btn = '0;
    repeat (8) tick();
    // out-of-range cur_floor: arrived ignored, selection from floor 1
    cur_floor = 3'd0;
    arrived   = 1'b1;
    tick();
    arrived = 1'b0;
    tick();
    check("oor_pending", 32'(pending), 32'h28);
    check("oor_target", 32'(target_floor), 32'h4);

    // 5. simultaneous press and arrived
    do_reset();
    cur_floor = 3'd3;
    btn = 7'b0100100;
    repeat (5) tick();
    arrived = 1'b1;
    tick();
    arrived = 1'b0;
    check("clear_wins", 32'(pending), 32'h20);
    btn = '0;
    repeat (8) tick();
    check("clear_stays", 32'(pending), 32'h20);

    // 6. asynchronous reset mid-operation
    do_reset();
    cur_floor = 3'd7;
    press_floors(7'b1010010);
    arrive(3'd7);
    cur_floor = 3'd6;
    press_floors(7'b1000000);
    check("mid_pending", 32'(pending), 32'h52);
    check("mid_dir", 32'(dir_up), 32'h0);
    check("mid_target", 32'(target_floor), 32'h5);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_pending", 32'(pending), 32'h0);
    check("async_target", 32'(target_floor), 32'h0);
    check("async_valid", 32'(target_valid), 32'h0);
    check("async_dir", 32'(dir_up), 32'h1);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_pending", 32'(pending), 32'h0);
    check("post_rst_valid", 32'(target_valid), 32'h0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
